// File: rtl/alu_d2_issuer.sv
// alu_d2_issuer: issue stage in front of a 2-cycle, handshake-less 32-bit ALU.
// Requests arrive on a valid/ready port and are registered onto alu_a/alu_b/
// alu_op. A valid/tag shift pipeline (v0..v2, t0..t2) follows each op through
// the ALU latency. When the op reaches v2, alu_s is written into a response
// FIFO that drains on a valid/ready port. req_ready is a credit check: FIFO
// occupancy plus ops still in flight must stay below DEPTH. This guarantees
// that every op in flight has a free FIFO slot when its result arrives.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_op, req_tag   request fields (op: 00 add, 01 sub, 10 and, 11 or)
//   alu_a, alu_b, alu_op            registered operands/op driven to the ALU
//   alu_s                           ALU result, valid 2 edges after operands change
//   resp_valid/resp_ready           response handshake
//   resp_data, resp_tag             FIFO head
//   idle                            nothing in flight and FIFO empty
module alu_d2_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_s,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + 4) + 1;

  logic             v0, v1, v2;
  logic [TAG_W-1:0] t0, t1, t2;

  logic [31:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic             accept, push, pop;
  logic [SW-1:0]    credit_use;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push       = v2;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = data_mem[head];
  assign resp_tag   = tag_mem[head];
  assign idle       = !(v0 | v1 | v2) && (count == '0);

  // A pop in this cycle frees a slot before any new op can reach the FIFO,
  // so it is credited back immediately.
  always_comb begin
    credit_use = SW'(count) + SW'(v0) + SW'(v1) + SW'(v2) - SW'(pop);
    req_ready  = (credit_use < SW'(DEPTH));
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      v0     <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= req_op;
      end
      v0 <= accept;
      v1 <= v0;
      v2 <= v1;
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tags and FIFO storage carry no reset; they are qualified by v*/count.
  always_ff @(posedge clk) begin
    if (accept) t0 <= req_tag;
    t1 <= t0;
    t2 <= t1;
    if (push) begin
      data_mem[tail] <= alu_s;
      tag_mem[tail]  <= t2;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule
